// File: rtl/tdc_pkg.sv
// tdc_pkg: shared FSM type, record field widths, popcount and record pack/unpack helpers
package tdc_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, FLUSH = 2'd2} state_e;
    localparam int POP_MAX = 256;
    localparam int REC_MAX = 64;
    function automatic int fine_w(input int taps);
        return $clog2(taps);
    endfunction
    function automatic int ch_w(input int nch);
        return nch > 1 ? $clog2(nch) : 1;
    endfunction
    function automatic int rec_w(input int nch, input int coarse_w, input int taps);
        return ch_w(nch) + 1 + coarse_w + fine_w(taps);
    endfunction
    function automatic int unsigned popcount(input logic [POP_MAX-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < POP_MAX; i++) n += 32'(v[i]);
        return n;
    endfunction
    function automatic logic [REC_MAX-1:0] rec_pack(input logic [31:0] ch, input logic to,
                                                    input logic [31:0] coarse, input logic [31:0] fine,
                                                    input int cw, input int fw);
        return (64'(ch) << (1 + cw + fw)) | (64'(to) << (cw + fw)) | (64'(coarse) << fw) | 64'(fine);
    endfunction
    function automatic logic [31:0] rec_field(input logic [REC_MAX-1:0] rec, input int lsb, input int w);
        return 32'((rec >> lsb) & ((64'd1 << w) - 64'd1));
    endfunction
endpackage

// File: rtl/tdc_result_fifo.sv
// tdc_result_fifo: synchronous first-word-fall-through FIFO; a full FIFO still accepts a write paired with a read
module tdc_result_fifo #(
    parameter int W = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_i,
    input  logic [W-1:0] wdata_i,
    input  logic         rd_i,
    output logic [W-1:0] rdata_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem_q [DEPTH];
    logic [AW-1:0] wp_q, rp_q;
    logic [AW:0] cnt_q;
    logic wr_ok, rd_ok;
    assign empty_o = cnt_q == '0;
    assign full_o = cnt_q == (AW+1)'(DEPTH);
    assign rd_ok = rd_i && !empty_o;
    assign wr_ok = wr_i && (!full_o || rd_ok);
    assign rdata_o = empty_o ? '0 : mem_q[rp_q];
    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[wp_q] <= wdata_i;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_q <= '0;
            rp_q <= '0;
            cnt_q <= '0;
        end else begin
            wp_q <= wr_ok ? wp_q + AW'(1) : wp_q;
            rp_q <= rd_ok ? rp_q + AW'(1) : rp_q;
            cnt_q <= cnt_q + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
        end
    end
endmodule

// File: rtl/tdc_multi_capture.sv
// tdc_multi_capture: multi-channel TDC; detects each channel's first 0->non-zero stop edge after start,
// emits {ch, timeout, coarse, fine} records through a FWFT FIFO, finishing once every enabled channel is pushed
module tdc_multi_capture
    import tdc_pkg::*;
#(
    parameter int TAPS = 32,
    parameter int COARSE_W = 8,
    parameter int NCH = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start_i,
    input  logic [NCH-1:0]                        ch_en_i,
    input  logic [NCH*TAPS-1:0]                   therm_i,
    output logic [rec_w(NCH, COARSE_W, TAPS)-1:0] res_data_o,
    output logic                                  res_valid_o,
    input  logic                                  res_ready_i,
    output logic                                  busy_o,
    output logic                                  done_o
);
    localparam int FINE_W = fine_w(TAPS);
    localparam int CH_W = ch_w(NCH);
    localparam int REC_W = rec_w(NCH, COARSE_W, TAPS);
    localparam logic [COARSE_W-1:0] CMAX = '1;
    state_e state_q, state_d;
    logic [COARSE_W-1:0] cnt_q, cnt_d, c2_q;
    logic [NCH-1:0][TAPS-1:0] s1_q, s2_q, pv_q;
    logic v1_q, v2_q, done_q, start, fin, last, pop, push, full, empty;
    logic [NCH-1:0] en_q, rec_q, pend_q, pushed_q, hit, set, sel_oh;
    logic [NCH-1:0][REC_W-1:0] prec_q, prec_d;
    logic [CH_W-1:0] sel;
    assign start = state_q == IDLE && start_i;
    assign fin = state_q != IDLE && pushed_q == en_q;
    assign last = v2_q && c2_q == CMAX;
    assign pop = res_valid_o && res_ready_i;
    assign push = |pend_q && (!full || pop);
    assign sel_oh = push ? NCH'(1) << sel : '0;
    // pv_q holds the previous s2 sample, so the cycle-0 sample is the reference for sample 1
    for (genvar c = 0; c < NCH; c++) begin : g_ch
        assign hit[c] = v2_q && en_q[c] && !rec_q[c] && |s2_q[c] && !(|pv_q[c]);
        assign set[c] = hit[c] || (last && en_q[c] && !rec_q[c]);
        assign prec_d[c] = REC_W'(rec_pack(32'(c), !hit[c], 32'(c2_q),
                                           hit[c] ? 32'(TAPS) - popcount(POP_MAX'(s2_q[c])) : 32'd0,
                                           COARSE_W, FINE_W));
    end
    always_comb begin
        sel = '0;
        for (int i = NCH - 1; i >= 0; i--) if (pend_q[i]) sel = CH_W'(i);
    end
    always_comb begin
        state_d = (start && |ch_en_i) ? ARMED : fin ? IDLE :
                  (state_q == ARMED && cnt_q == CMAX - COARSE_W'(1)) ? FLUSH : state_q;
        cnt_d = start ? '0 : (state_q == ARMED && cnt_q != CMAX) ? cnt_q + COARSE_W'(1) : cnt_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q <= '0;
            c2_q <= '0;
            s1_q <= '0;
            s2_q <= '0;
            pv_q <= '0;
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            done_q <= 1'b0;
            en_q <= '0;
            rec_q <= '0;
            pend_q <= '0;
            pushed_q <= '0;
            prec_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            c2_q <= cnt_q;
            s1_q <= therm_i;
            s2_q <= s1_q;
            pv_q <= s2_q;
            v1_q <= state_q == ARMED && !fin;
            v2_q <= v1_q && !fin;
            done_q <= (start && !(|ch_en_i)) || fin;
            en_q <= start ? ch_en_i : en_q;
            rec_q <= start ? '0 : rec_q | set;
            pend_q <= start ? '0 : (pend_q & ~sel_oh) | set;
            pushed_q <= start ? '0 : pushed_q | sel_oh;
            for (int i = 0; i < NCH; i++) if (set[i]) prec_q[i] <= prec_d[i];
        end
    end
    tdc_result_fifo #(.W(REC_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk),
        .rst(rst),
        .wr_i(push),
        .wdata_i(prec_q[sel]),
        .rd_i(pop),
        .rdata_o(res_data_o),
        .full_o(full),
        .empty_o(empty)
    );
    assign res_valid_o = !empty;
    assign busy_o = state_q != IDLE;
    assign done_o = done_q;
endmodule

// File: doc/tdc_multi_capture.md
# tdc_multi_capture

Parametrised multi-channel time-to-digital capture core, the next generation of the single-channel `tt_um_roy1707018_tdc` user design. It takes the sampled thermometer codes of NCH external tapped delay lines, detects each channel's stop edge after a common start, and combines a coarse cycle count with a bubble-tolerant fine code. It also generates timeout records for channels that never fire and delivers ordered result records through a valid/ready FIFO. It sits between the delay-line macros and the Tiny Tapeout I/O readout logic.

## Interface
- TAPS, 32: delay-line taps per channel; power of 2, ≥4. FINE_W = log2(TAPS).
- COARSE_W, 8: coarse counter width. CMAX = 2^COARSE_W−1.
- NCH, 2: channel count, 1..8. CH_W = max(1, log2(NCH)).
- FIFO_DEPTH, 4: result FIFO depth; power of 2, ≥2.
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start_i  in  1  start pulse; sampled on clk.
- ch_en_i  in  NCH  channel enable mask, latched on accepted start.
- therm_i  in  NCH*TAPS  thermometer codes; channel c at [c*TAPS +: TAPS].
- res_data_o  out  CH_W+1+COARSE_W+FINE_W  record {ch, timeout, coarse, fine}.
- res_valid_o  out  1  FIFO head valid (first-word fall-through).
- res_ready_i  in  1  consumer accepts head when high with valid.
- busy_o  out  1  measurement in progress.
- done_o  out  1  one-cycle pulse when a measurement completes.

## Operation
- Reset values: all outputs 0; FSM IDLE; FIFO empty; counter 0; sync and pending registers cleared.
- FSM: IDLE → ARMED on start_i=1. ARMED → FLUSH after the sample with coarse=CMAX. FLUSH → IDLE once every enabled channel's record is pushed.
- start_i is ignored outside IDLE. start_i with ch_en_i=0 → straight to IDLE with a done pulse and no records.
- Coarse: the start edge is cycle 0. The therm_i sample taken at cycle k carries coarse=k, for k=1..CMAX.
- Sync: therm_i passes two register stages, s1 and s2. Coarse is delayed identically.
- Hit: an enabled, not-yet-hit channel hits when its s2 code is non-zero and its previous s2 code was all-zero. The previous code is preloaded from the sample at cycle 0, so a line already high at start needs a 0→non-zero transition.
- Fine: fine = TAPS − popcount(s2 code). A code of all ones gives 0.
- Each channel records at most once per measurement. Later transitions are ignored.
- Timeout: channels without a hit after sample CMAX get the record {ch, 1, CMAX, 0}.
- Pending: each channel has one pending record register. Each cycle the lowest-index pending channel pushes if the FIFO is not full.
- FIFO full: pending records stall with no loss. Measurement completion is delayed, and busy_o stays 1.
- FIFO: a pop occurs on res_valid_o && res_ready_i. A push and a pop in the same cycle are allowed when full. Ordering is strict FIFO.
- Reset mid-measurement clears everything, including FIFO contents.

## Timing
- Hit sample at edge k: s1 at k, s2 at k+1, pending set at k+2, push at k+3. res_valid_o is high after edge k+3 when the FIFO was empty and no lower-index channel is pending.
- Simultaneous hits push on consecutive cycles in ascending channel order.
- busy_o rises the cycle after the start edge. It falls with done_o in the same cycle, the cycle after the last push.
- Counter saturates at CMAX and never wraps.

## Structure
- Package tdc_pkg holds the FSM state enum (IDLE, ARMED, FLUSH), the record field-width functions, and the record pack/unpack helpers.
- Sub-module tdc_result_fifo: parametrised synchronous FWFT FIFO with full/empty flags.
- Popcount is a function in tdc_pkg, not a module.

## Test plan
Defaults: TAPS=32, COARSE_W=8, NCH=2, FIFO_DEPTH=4.
- Reset: assert rst asynchronously mid-cycle → all outputs 0 immediately. Release, then start → normal measurement.
- Single hit: start at cycle 0, ch0 therm 0→0x000000FF at cycle 5, ch_en=01 → record {0,0,5,24}, res_valid at edge 8, done_o one cycle after the push.
- Simultaneous hits: both channels 0→0x0000FFFF at cycle 3 → {0,0,3,16} then {1,0,3,16} on consecutive cycles.
- Timeout: ch0 hits at cycle 10 with 0xFFFFFFFF, ch1 silent → {0,0,10,0} then {1,1,255,0}. busy_o stays high until after the timeout push.
- Backpressure: res_ready=0 across 3 two-channel measurements → FIFO holds 4, the third measurement stalls with busy_o=1. Raise ready → all 6 records arrive in order.
- Edge cases: line high at start produces no hit until it drops to 0 and rises. start_i while ARMED is ignored. rst at cycle 50 of ARMED leaves no records and busy_o=0.
